// File: rtl/ts_pkg.sv
// Shared definitions for the multi-channel timestamper.
// TS_CAPTURE_EPOCH_EN widens each captured stamp from {time} to {epoch, time}.
package ts_pkg;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    TRG  = 2'b11
  } exec_state_e;

`ifdef TS_CAPTURE_EPOCH_EN
  localparam bit CAPTURE_EPOCH = 1'b1;
`else
  localparam bit CAPTURE_EPOCH = 1'b0;
`endif

  // Width of one channel's stamp field in O_CAP_TIME.
  function automatic int cap_width(input int ts_w, input int ep_w);
    return CAPTURE_EPOCH ? ts_w + ep_w : ts_w;
  endfunction

endpackage

// File: rtl/ts_capture_channel.sv
// One trigger-capture channel: rising-edge detect, stamp register,
// valid/ready output handshake and a sticky lost-capture flag.
module ts_capture_channel
  import ts_pkg::*;
#(
  parameter int CAP_W = 16
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESETN,
  input  logic             clear,
  input  logic             run_en,
  input  logic             trig,
  input  logic             ready,
  input  logic [CAP_W-1:0] stamp_in,
  output logic [CAP_W-1:0] cap_time,
  output logic             cap_valid,
  output logic             cap_ovf
);

  logic trig_q;
  logic rise;

  assign rise = trig & ~trig_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      trig_q    <= 1'b0;
      cap_time  <= '0;
      cap_valid <= 1'b0;
      cap_ovf   <= 1'b0;
    end else if (clear) begin
      trig_q    <= 1'b0;
      cap_valid <= 1'b0;
      cap_ovf   <= 1'b0;
    end else if (run_en) begin
      trig_q <= trig;
      if (rise) begin
        // A completing transfer frees the slot in the same cycle: no bubble.
        if (!cap_valid || ready) begin
          cap_time  <= stamp_in;
          cap_valid <= 1'b1;
        end else begin
          cap_ovf <= 1'b1;
        end
      end else if (cap_valid && ready) begin
        cap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_channel_timestamper.sv
// Free-running prescaled time base with epoch counter and NUM_CH capture
// channels. Define TS_CAPTURE_EPOCH_EN to capture {epoch, time} stamps.
module multi_channel_timestamper
  import ts_pkg::*;
#(
  parameter int TIME_STAMP_WIDTH = 16,
  parameter int EPOCH_WIDTH      = 8,
  parameter int DIV_WIDTH        = 8,
  parameter int NUM_CH           = 4
) (
  input  logic                                                  AXIS_ACLK,
  input  logic                                                  AXIS_ARESETN,
  input  logic [1:0]                                            EXEC_STATE,
  input  logic [DIV_WIDTH-1:0]                                  I_DIVIDE,
  input  logic [NUM_CH-1:0]                                     I_TRIG,
  input  logic [NUM_CH-1:0]                                     I_CAP_READY,
  output logic [TIME_STAMP_WIDTH-1:0]                           O_CURRENT_TIME,
  output logic [EPOCH_WIDTH-1:0]                                O_EPOCH,
  output logic [NUM_CH*cap_width(TIME_STAMP_WIDTH,EPOCH_WIDTH)-1:0] O_CAP_TIME,
  output logic [NUM_CH-1:0]                                     O_CAP_VALID,
  output logic [NUM_CH-1:0]                                     O_CAP_OVF
);

  localparam int CAP_W = cap_width(TIME_STAMP_WIDTH, EPOCH_WIDTH);

  logic                        run_next;
  logic                        run_en;
  logic [DIV_WIDTH-1:0]        div_in;
  logic [DIV_WIDTH-1:0]        div_eff;
  logic [DIV_WIDTH-1:0]        div_q;
  logic [DIV_WIDTH-1:0]        div_d;
  logic [DIV_WIDTH-1:0]        presc_q;
  logic [DIV_WIDTH-1:0]        presc_d;
  logic [TIME_STAMP_WIDTH-1:0] time_d;
  logic [EPOCH_WIDTH-1:0]      epoch_d;
  logic                        tick;
  logic                        time_max;
  logic [CAP_W-1:0]            stamp;

  // Clearing keys off the run_en next-state so state is already 0 in the
  // first cycle that run_en reads 0.
  assign run_next = (EXEC_STATE != INIT);
  assign div_in   = (I_DIVIDE == '0) ? DIV_WIDTH'(1) : I_DIVIDE;
  // div_q is only 0 before the first run cycle has latched a divisor.
  assign div_eff  = (div_q == '0) ? div_in : div_q;
  assign tick     = run_en && (presc_q == div_eff - DIV_WIDTH'(1));
  assign time_max = (O_CURRENT_TIME == '1);

  // NOTE: every combinational output gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    presc_d = presc_q;
    div_d   = div_q;
    time_d  = O_CURRENT_TIME;
    epoch_d = O_EPOCH;
    if (!run_next) begin
      presc_d = '0;
      div_d   = '0;
      time_d  = '0;
      epoch_d = '0;
    end else if (run_en) begin
      presc_d = tick ? '0 : presc_q + DIV_WIDTH'(1);
      if (tick || (div_q == '0)) begin
        div_d = div_in;
      end
      if (tick) begin
        time_d = O_CURRENT_TIME + TIME_STAMP_WIDTH'(1);
        if (time_max) begin
          epoch_d = O_EPOCH + EPOCH_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      run_en         <= 1'b0;
      presc_q        <= '0;
      div_q          <= '0;
      O_CURRENT_TIME <= '0;
      O_EPOCH        <= '0;
    end else begin
      run_en         <= run_next;
      presc_q        <= presc_d;
      div_q          <= div_d;
      O_CURRENT_TIME <= time_d;
      O_EPOCH        <= epoch_d;
    end
  end

`ifdef TS_CAPTURE_EPOCH_EN
  assign stamp = {O_EPOCH, O_CURRENT_TIME};
`else
  assign stamp = O_CURRENT_TIME;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ts_capture_channel #(
      .CAP_W(CAP_W)
    ) u_ch (
      .AXIS_ACLK   (AXIS_ACLK),
      .AXIS_ARESETN(AXIS_ARESETN),
      .clear       (~run_next),
      .run_en      (run_en),
      .trig        (I_TRIG[k]),
      .ready       (I_CAP_READY[k]),
      .stamp_in    (stamp),
      .cap_time    (O_CAP_TIME[k*CAP_W +: CAP_W]),
      .cap_valid   (O_CAP_VALID[k]),
      .cap_ovf     (O_CAP_OVF[k])
    );
  end

endmodule

// File: tb/tb_multi_channel_timestamper.sv
// Scoreboard bench for multi_channel_timestamper (4-bit time to reach wraps).
module tb_multi_channel_timestamper;

  localparam int TS  = 4;
  localparam int EP  = 8;
  localparam int DW  = 8;
  localparam int NCH = 4;
`ifdef TS_CAPTURE_EPOCH_EN
  localparam int CAP_W = TS + EP;
`else
  localparam int CAP_W = TS;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       exec_state = 2'b00;
  logic [DW-1:0]    divide = 8'd1;
  logic [NCH-1:0]   trig = '0;
  logic [NCH-1:0]   ready = '0;
  logic [TS-1:0]    cur_time;
  logic [EP-1:0]    epoch;
  logic [NCH*CAP_W-1:0] cap_time;
  logic [NCH-1:0]   cap_valid;
  logic [NCH-1:0]   cap_ovf;

  int checks = 0;
  int errors = 0;
  logic [CAP_W-1:0] sb [NCH][$];

  multi_channel_timestamper #(
    .TIME_STAMP_WIDTH(TS),
    .EPOCH_WIDTH     (EP),
    .DIV_WIDTH       (DW),
    .NUM_CH          (NCH)
  ) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .EXEC_STATE    (exec_state),
    .I_DIVIDE      (divide),
    .I_TRIG        (trig),
    .I_CAP_READY   (ready),
    .O_CURRENT_TIME(cur_time),
    .O_EPOCH       (epoch),
    .O_CAP_TIME    (cap_time),
    .O_CAP_VALID   (cap_valid),
    .O_CAP_OVF     (cap_ovf)
  );

  always #5 clk = ~clk;

  // Stamps in these scenarios are all taken in epoch 0, so {0,t} in both builds.
  function automatic logic [CAP_W-1:0] exp_stamp(input int t);
    return CAP_W'(t);
  endfunction

  // Transfers are observed mid-cycle, when VALID and READY are both stable.
  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (rst_n && cap_valid[k] && ready[k]) begin
        checks++;
        if (sb[k].size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected ch%0d got %h expected no transfer",
                   k, cap_time[k*CAP_W +: CAP_W]);
        end else begin
          logic [CAP_W-1:0] exp;
          exp = sb[k].pop_front();
          if (cap_time[k*CAP_W +: CAP_W] !== exp) begin
            errors++;
            $display("FAIL sb_stamp ch%0d got %h expected %h",
                     k, cap_time[k*CAP_W +: CAP_W], exp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first run_en cycle, where time is 0.
  task automatic restart(input logic [DW-1:0] div);
    trig = '0;
    ready = '0;
    exec_state = 2'b00;
    step();
    exec_state = 2'b11;
    divide = div;
    step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({cur_time, epoch, cap_time, cap_valid, cap_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0",
               {cur_time, epoch, cap_time, cap_valid, cap_ovf});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    checks++;
    if ({cur_time, epoch, cap_valid, cap_ovf} !== '0) begin
      errors++;
      $display("FAIL idle_outputs got %h expected 0", {cur_time, epoch, cap_valid, cap_ovf});
    end
  endtask

  task automatic test_divide();
    restart(8'd5);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cur_time !== TS'(k / 5)) begin
        errors++;
        $display("FAIL div5_time cyc%0d got %0d expected %0d", k, cur_time, k / 5);
      end
      step();
    end
    restart(8'd0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cur_time !== TS'(k)) begin
        errors++;
        $display("FAIL div0_time cyc%0d got %0d expected %0d", k, cur_time, k);
      end
      step();
    end
  endtask

  task automatic test_div_change();
    int exp;
    restart(8'd4);
    for (int k = 0; k < 14; k++) begin
      if (k == 5) divide = 8'd2;
      exp = (k < 4) ? 0 : (k < 8) ? 1 : 2 + (k - 8) / 2;
      checks++;
      if (cur_time !== TS'(exp)) begin
        errors++;
        $display("FAIL divchg_time cyc%0d got %0d expected %0d", k, cur_time, exp);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    restart(8'd1);
    for (int k = 0; k < 21; k++) begin
      if (k == 15) begin
        trig[0] = 1'b1;
        sb[0].push_back(exp_stamp(15));
      end
      if (k == 16) begin
        trig[0] = 1'b0;
        ready[0] = 1'b1;
      end
      if (k == 17) ready[0] = 1'b0;
      checks++;
      if (cur_time !== TS'(k % 16) || epoch !== EP'(k / 16)) begin
        errors++;
        $display("FAIL wrap cyc%0d got time %0d epoch %0d expected %0d %0d",
                 k, cur_time, epoch, k % 16, k / 16);
      end
      step();
    end
    repeat (4095 - 21) step();
    checks++;
    if (cur_time !== 4'd15 || epoch !== 8'd255) begin
      errors++;
      $display("FAIL epoch_top got %0d/%0d expected 255/15", epoch, cur_time);
    end
    step();
    checks++;
    if (cur_time !== 4'd0 || epoch !== 8'd0) begin
      errors++;
      $display("FAIL epoch_wrap got %0d/%0d expected 0/0", epoch, cur_time);
    end
  endtask

  task automatic test_capture_ovf();
    restart(8'd1);
    repeat (7) step();
    trig[0] = 1'b1;
    sb[0].push_back(exp_stamp(7));
    step();
    checks++;
    if (cap_valid[0] !== 1'b1 || cap_time[0 +: CAP_W] !== exp_stamp(7)) begin
      errors++;
      $display("FAIL cap_first got valid %b stamp %h expected 1 %h",
               cap_valid[0], cap_time[0 +: CAP_W], exp_stamp(7));
    end
    trig[0] = 1'b0;
    step();
    trig[0] = 1'b1;
    step();
    checks++;
    if (cap_ovf[0] !== 1'b1 || cap_valid[0] !== 1'b1 || cap_time[0 +: CAP_W] !== exp_stamp(7)) begin
      errors++;
      $display("FAIL cap_ovf got ovf %b valid %b stamp %h expected 1 1 %h",
               cap_ovf[0], cap_valid[0], cap_time[0 +: CAP_W], exp_stamp(7));
    end
    trig[0] = 1'b0;
    ready[0] = 1'b1;
    step();
    checks++;
    if (cap_valid[0] !== 1'b0 || cap_ovf[0] !== 1'b1) begin
      errors++;
      $display("FAIL cap_drain got valid %b ovf %b expected 0 1", cap_valid[0], cap_ovf[0]);
    end
    ready[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    restart(8'd1);
    checks++;
    if (cap_ovf !== '0) begin
      errors++;
      $display("FAIL ovf_cleared got %b expected 0", cap_ovf);
    end
    repeat (3) step();
    trig[1] = 1'b1;
    sb[1].push_back(exp_stamp(3));
    step();
    trig[1] = 1'b0;
    repeat (2) step();
    trig[1] = 1'b1;
    ready[1] = 1'b1;
    sb[1].push_back(exp_stamp(6));
    step();
    checks++;
    if (cap_valid[1] !== 1'b1 || cap_time[CAP_W +: CAP_W] !== exp_stamp(6)) begin
      errors++;
      $display("FAIL b2b_reload got valid %b stamp %h expected 1 %h",
               cap_valid[1], cap_time[CAP_W +: CAP_W], exp_stamp(6));
    end
    trig[1] = 1'b0;
    step();
    checks++;
    if (cap_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got %b expected 0", cap_valid[1]);
    end
    ready[1] = 1'b0;
    trig[3:2] = 2'b11;
    sb[2].push_back(exp_stamp(8));
    sb[3].push_back(exp_stamp(8));
    step();
    checks++;
    if (cap_valid !== 4'b1100 || cap_time[2*CAP_W +: CAP_W] !== cap_time[3*CAP_W +: CAP_W]) begin
      errors++;
      $display("FAIL simul_capture got valid %b stamps %h %h expected 1100 equal",
               cap_valid, cap_time[2*CAP_W +: CAP_W], cap_time[3*CAP_W +: CAP_W]);
    end
    trig = '0;
    ready[3:2] = 2'b11;
    step();
    checks++;
    if (cap_valid !== '0) begin
      errors++;
      $display("FAIL simul_drain got %b expected 0", cap_valid);
    end
    ready = '0;
  endtask

  task automatic test_reset_mid();
    restart(8'd3);
    step();
    trig[0] = 1'b1;
    step();
    trig[0] = 1'b0;
    step();
    trig[0] = 1'b1;
    step();
    trig[0] = 1'b0;
    checks++;
    if (cap_valid[0] !== 1'b1 || cap_ovf[0] !== 1'b1 || cur_time !== 4'd1) begin
      errors++;
      $display("FAIL pre_reset got valid %b ovf %b time %0d expected 1 1 1",
               cap_valid[0], cap_ovf[0], cur_time);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({cur_time, epoch, cap_time, cap_valid, cap_ovf} !== '0) begin
      errors++;
      $display("FAIL async_reset got %h expected 0",
               {cur_time, epoch, cap_time, cap_valid, cap_ovf});
    end
    #2 rst_n = 1'b1;
    step();
    repeat (3) step();
    checks++;
    if (cur_time !== 4'd1) begin
      errors++;
      $display("FAIL reset_restart got %0d expected 1", cur_time);
    end
  endtask

  task automatic test_init_mid();
    restart(8'd1);
    step();
    trig[1] = 1'b1;
    step();
    trig[1] = 1'b0;
    step();
    trig[1] = 1'b1;
    step();
    trig[1] = 1'b0;
    checks++;
    if (cap_valid[1] !== 1'b1 || cap_ovf[1] !== 1'b1 || cur_time !== 4'd4) begin
      errors++;
      $display("FAIL pre_init got valid %b ovf %b time %0d expected 1 1 4",
               cap_valid[1], cap_ovf[1], cur_time);
    end
    exec_state = 2'b00;
    step();
    checks++;
    if ({cur_time, epoch, cap_valid, cap_ovf} !== '0) begin
      errors++;
      $display("FAIL init_clear got %h expected 0", {cur_time, epoch, cap_valid, cap_ovf});
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_change();
    test_wrap();
    test_capture_ovf();
    test_back_to_back();
    test_reset_mid();
    test_init_mid();
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (sb[k].size() != 0) begin
        errors++;
        $display("FAIL sb_leftover ch%0d got %0d pending expected 0", k, sb[k].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_channel_timestamper.md
Name: multi_channel_timestamper

Overview:
- Parametrised successor to the single prescaled time counter: a free-running time base with a runtime-programmable prescaler and a wrap (epoch) counter.
- Adds NUM_CH trigger-capture channels. Each channel latches the time on a trigger rising edge and offers it on a valid/ready handshake.
- Sits beside the trigger logic on the AXIS_ACLK domain and feeds timestamps to the event packer.

Parameters:
- TIME_STAMP_WIDTH, 16, width of the time counter.
- EPOCH_WIDTH, 8, width of the wrap counter.
- DIV_WIDTH, 8, width of the runtime divide input.
- NUM_CH, 4, number of capture channels (1..16).

Ports:
- AXIS_ACLK  in  1  clock.
- AXIS_ARESETN  in  1  asynchronous active-low reset.
- EXEC_STATE  in  2  run control; INIT=2'b00 stops and clears, any other value runs.
- I_DIVIDE  in  DIV_WIDTH  ticks per time increment; 0 is treated as 1.
- I_TRIG  in  NUM_CH  per-channel trigger level, synchronous to AXIS_ACLK.
- I_CAP_READY  in  NUM_CH  consumer ready, one per channel.
- O_CURRENT_TIME  out  TIME_STAMP_WIDTH  current time.
- O_EPOCH  out  EPOCH_WIDTH  number of time wraps since the run started.
- O_CAP_TIME  out  NUM_CH*CAP_W  captured stamps; channel k occupies bits [k*CAP_W +: CAP_W].
- O_CAP_VALID  out  NUM_CH  capture pending, one per channel.
- O_CAP_OVF  out  NUM_CH  sticky lost-capture flag, one per channel.

Behaviour:
- Reset (async assert, sync release): every output register and internal register is 0.
- Run enable: run_en is a registered copy of (EXEC_STATE != INIT), so run_en lags EXEC_STATE by 1 cycle.
- While run_en=0: time, epoch, prescaler, trigger-edge history, O_CAP_VALID and O_CAP_OVF are all held at 0.
- Divide latch: div_q loads max(I_DIVIDE,1) on the first run_en cycle and again on every tick. A change to I_DIVIDE therefore takes effect only at a tick boundary, with no runt periods.
- Prescaler: counts 0..div_q-1 while running. tick=1 when prescaler==div_q-1, and the prescaler then returns to 0. With div_q=1, tick=1 every cycle.
- Time counter: increments on tick.
  - At 2^TIME_STAMP_WIDTH-1 a tick wraps time to 0 and increments epoch in the same cycle.
  - Epoch wraps modulo 2^EPOCH_WIDTH.
- Edge detect: trig_q is I_TRIG registered once. A rising edge on channel k is I_TRIG[k] & ~trig_q[k].
- Capture: on an edge in cycle n, the channel stores O_CURRENT_TIME as it stood in cycle n (the pre-increment value). O_CAP_VALID rises in cycle n+1.
- Handshake: the transfer completes on a cycle where VALID & READY. VALID stays high and O_CAP_TIME stays stable until the transfer.
- Simultaneous edge and completing transfer: the new stamp loads and VALID stays 1, so no bubble.
- Edge while VALID=1 and READY=0: the old stamp is kept and O_CAP_OVF[k] sets.
- O_CAP_OVF[k] is cleared only by reset or run_en=0.
- Independence: channels are independent. Simultaneous edges on several channels all capture the same time value.
- Reset mid-operation: everything returns to 0 immediately. A run restarts cleanly 1 cycle after EXEC_STATE leaves INIT.
- INIT mid-run: pending captures are discarded.
- Widths: CAP_W = TIME_STAMP_WIDTH, or TIME_STAMP_WIDTH+EPOCH_WIDTH when the optional feature below is compiled in.

Optional Feature:
- Macro: TS_CAPTURE_EPOCH_EN.
- Defined: CAP_W = EPOCH_WIDTH+TIME_STAMP_WIDTH. Each stamp is {epoch,time}, sampled in the same cycle. On a wrap cycle the stamp is the pre-wrap pair {E, 2^W-1}.
- Undefined: CAP_W = TIME_STAMP_WIDTH and the stamp carries time only. O_EPOCH is still driven.

Decomposition:
- Package ts_pkg holds:
  - The EXEC_STATE encodings INIT=2'b00 and TRG=2'b11.
  - A function computing CAP_W from the widths and the macro.
- Sub-module ts_capture_channel holds one channel: edge register, stamp register, valid and overflow. The top instantiates it NUM_CH times in a generate loop.
- The top keeps the prescaler, time and epoch counters.

Test Plan:
- Reset, then EXEC_STATE=11 with I_DIVIDE=5 -> time 0→1 five cycles after the first run_en cycle, then +1 every 5 cycles. I_DIVIDE=0 -> time increments every cycle.
- TIME_STAMP_WIDTH=4, I_DIVIDE=1, run 16 ticks -> time goes 15→0 and O_EPOCH goes 0→1 in the same cycle. With TS_CAPTURE_EPOCH_EN, an edge on the wrap cycle captures {0,15}.
- Change I_DIVIDE from 4 to 2 mid-period -> the current 4-cycle period completes, and following periods are 2 cycles.
- Ch0 edge while time=7 with I_CAP_READY=0 -> O_CAP_VALID[0]=1 next cycle and O_CAP_TIME ch0=7. A second edge at time=9 -> stamp stays 7 and O_CAP_OVF[0]=1. Then READY=1 -> transfer completes and VALID falls.
- Ch1 edge in the same cycle READY[1]=1 completes a pending stamp 3, with time=6 -> VALID[1] stays 1 and the stamp becomes 6. Simultaneous edges on ch2 and ch3 -> both capture the same time value.
- Assert AXIS_ARESETN=0 asynchronously mid-period with valid and overflow set -> all outputs are 0 immediately. Returning EXEC_STATE to INIT mid-run -> time, epoch, valid and overflow are all cleared one cycle later.
